// File: rtl/if_fetch_stage.sv
// MIPS32 instruction-fetch stage: PC ownership, imem addressing, IF/ID register.
// Handles stall, EX redirect/flush and a sticky fetch-error halt.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 256,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_instr_i,
   output logic [31:0] ifid_pc_o,
   output logic [31:0] ifid_pc4_o,
   output logic [31:0] ifid_instr_o,
   output logic        ifid_valid_o,
   output logic        fetch_err_o,
   output logic [31:0] fetch_cnt_o
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      ERR  = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] instr;
      logic        valid;
   } ifid_t;

   localparam logic [29:0] LIMIT = IMEM_WORDS[29:0];
   localparam ifid_t BUBBLE = '{
      pc: 32'h0, pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0
   };

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   ifid_t       ifid_q, ifid_d;
   logic        err_q, err_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] pc_inc;

   assign pc_inc = pc_q + 32'd4;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ifid_d  = ifid_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (redirect_i) begin
               pc_d   = {redirect_pc_i[31:2], 2'b00};
               ifid_d = BUBBLE;
               if (redirect_pc_i[1:0] != 2'b00) begin
                  err_d   = 1'b1;
                  state_d = ERR;
               end
            end else if (flush_i) begin
               ifid_d = BUBBLE;
               if (!stall_i) pc_d = pc_inc;
            end else if (stall_i) begin
               pc_d = pc_q;
            end else if (pc_q[31:2] >= LIMIT) begin
               // fetch beyond the memory: halt with PC parked
               ifid_d  = BUBBLE;
               err_d   = 1'b1;
               state_d = ERR;
            end else begin
               pc_d   = pc_inc;
               ifid_d = '{
                  pc: pc_q, pc4: pc_inc,
                  instr: imem_instr_i, valid: 1'b1
               };
               cnt_d  = cnt_q + 32'd1;
            end
         end
         ERR: begin
            ifid_d = BUBBLE;
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         ifid_q  <= BUBBLE;
         err_q   <= 1'b0;
         cnt_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ifid_q  <= ifid_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign imem_addr_o  = pc_q;
   assign ifid_pc_o    = ifid_q.pc;
   assign ifid_pc4_o   = ifid_q.pc4;
   assign ifid_instr_o = ifid_q.instr;
   assign ifid_valid_o = ifid_q.valid;
   assign fetch_err_o  = err_q;
   assign fetch_cnt_o  = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized
// hazard traffic against a cycle-level reference model.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, flush = 1'b0, redir = 1'b0;
   logic [31:0] rpc = 32'h0;
   logic [31:0] addr, instr;
   logic [31:0] o_pc, o_pc4, o_instr, o_cnt;
   logic        o_valid, o_err;

   logic        rst4 = 1'b0;
   logic        z_stall = 1'b0, z_flush = 1'b0, z_redir = 1'b0;
   logic [31:0] z_rpc = 32'h0;
   logic [31:0] a4, i4, p4, pp4, in4, c4;
   logic        v4, e4;

   logic [31:0] mem [256];
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] rd(input logic [31:0] a);
      if (a[31:2] < 30'd256) return mem[a[9:2]];
      return 32'hDEAD_BEEF;
   endfunction

   assign instr = rd(addr);
   assign i4    = rd(a4);

   if_fetch_stage dut (
      .clk(clk), .rst_n(rst_n),
      .stall_i(stall), .flush_i(flush),
      .redirect_i(redir), .redirect_pc_i(rpc),
      .imem_addr_o(addr), .imem_instr_i(instr),
      .ifid_pc_o(o_pc), .ifid_pc4_o(o_pc4),
      .ifid_instr_o(o_instr), .ifid_valid_o(o_valid),
      .fetch_err_o(o_err), .fetch_cnt_o(o_cnt)
   );

   if_fetch_stage #(.IMEM_WORDS(4)) dut4 (
      .clk(clk), .rst_n(rst4),
      .stall_i(z_stall), .flush_i(z_flush),
      .redirect_i(z_redir), .redirect_pc_i(z_rpc),
      .imem_addr_o(a4), .imem_instr_i(i4),
      .ifid_pc_o(p4), .ifid_pc4_o(pp4),
      .ifid_instr_o(in4), .ifid_valid_o(v4),
      .fetch_err_o(e4), .fetch_cnt_o(c4)
   );

   // reference model state
   bit          m_boot, m_err;
   logic [31:0] m_pc, m_ipc, m_ipc4, m_iins, m_cnt;
   bit          m_val;

   task automatic m_reset();
      m_boot = 1; m_err = 0; m_pc = 0;
      m_ipc = 0; m_ipc4 = 0; m_iins = 0; m_val = 0; m_cnt = 0;
   endtask

   task automatic m_bubble();
      m_ipc = 0; m_ipc4 = 0; m_iins = 0; m_val = 0;
   endtask

   task automatic m_clock();
      if (m_boot) m_boot = 0;
      else if (m_err) m_bubble();
      else if (redir) begin
         m_pc = rpc - 32'(rpc % 4);
         m_bubble();
         if (rpc % 4 != 0) m_err = 1;
      end else if (flush) begin
         m_bubble();
         if (!stall) m_pc = m_pc + 4;
      end else if (stall) begin
      end else if (m_pc / 4 >= 256) begin
         m_bubble();
         m_err = 1;
      end else begin
         m_ipc = m_pc; m_ipc4 = m_pc + 4;
         m_iins = rd(m_pc); m_val = 1;
         m_pc = m_pc + 4; m_cnt = m_cnt + 1;
      end
   endtask

   task automatic step();
      m_clock();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      stall = 0; flush = 0; redir = 0; rpc = 0;
      @(posedge clk); #1;
      rst_n = 0;
      m_reset();
      #2;
      rst_n = 1;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      rst_n = 0;
      #2;
      n_checks++;
      if ({addr, o_pc, o_pc4, o_instr, o_valid, o_err, o_cnt} !==
          {32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL reset: addr=%h pc=%h v=%b err=%b cnt=%0d",
                  addr, o_pc, o_valid, o_err, o_cnt);
      end
      rst_n = 1;
      m_reset();
   endtask

   task automatic test_boot_and_fetch();
      step();
      n_checks++;
      if (o_valid !== 1'b0 || addr !== 32'h0) begin
         n_fail++;
         $display("FAIL boot: valid=%b addr=%h want 0/0", o_valid, addr);
      end
      step();
      n_checks++;
      if ({o_pc, o_pc4, o_instr, o_valid, o_cnt} !==
          {32'h0, 32'h4, 32'h1, 1'b1, 32'd1}) begin
         n_fail++;
         $display("FAIL first_fetch: pc=%h pc4=%h ins=%h v=%b cnt=%0d",
                  o_pc, o_pc4, o_instr, o_valid, o_cnt);
      end
      step();
      n_checks++;
      if ({o_pc, o_instr, o_valid, o_cnt, addr} !==
          {32'h4, 32'h2, 1'b1, 32'd2, 32'h8}) begin
         n_fail++;
         $display("FAIL second_fetch: pc=%h ins=%h cnt=%0d addr=%h want 4/2/2/8",
                  o_pc, o_instr, o_cnt, addr);
      end
   endtask

   task automatic test_stall();
      step();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if ({o_pc, o_instr, o_valid, addr, o_cnt} !==
             {32'h8, 32'h3, 1'b1, 32'hC, 32'd3}) begin
            n_fail++;
            $display("FAIL stall_hold%0d: pc=%h addr=%h cnt=%0d want 8/c/3",
                     i, o_pc, addr, o_cnt);
         end
      end
      stall = 0;
      step();
      n_checks++;
      if (o_pc !== 32'hC || o_instr !== 32'h4 || o_cnt !== 32'd4) begin
         n_fail++;
         $display("FAIL stall_resume: pc=%h ins=%h cnt=%0d want c/4/4",
                  o_pc, o_instr, o_cnt);
      end
   endtask

   task automatic test_redirect();
      redir = 1; rpc = 32'h40; stall = 1;
      step();
      redir = 0; stall = 0;
      n_checks++;
      if (o_valid !== 1'b0 || addr !== 32'h40 || o_cnt !== 32'd4) begin
         n_fail++;
         $display("FAIL redirect_bubble: v=%b addr=%h cnt=%0d want 0/40/4",
                  o_valid, addr, o_cnt);
      end
      step();
      n_checks++;
      if ({o_pc, o_instr, o_valid} !== {32'h40, 32'd17, 1'b1}) begin
         n_fail++;
         $display("FAIL redirect_target: pc=%h ins=%h v=%b want 40/11/1",
                  o_pc, o_instr, o_valid);
      end
   endtask

   task automatic test_misaligned();
      redir = 1; rpc = 32'h42;
      step();
      redir = 0;
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (o_err !== 1'b1 || addr !== 32'h40 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_sticky%0d: err=%b addr=%h v=%b want 1/40/0",
                     i, o_err, addr, o_valid);
         end
         stall = 1'($urandom); flush = 1'($urandom);
         redir = 1'($urandom); rpc = $urandom & 32'h3FC;
         step();
      end
      do_reset();
      n_checks++;
      if (o_err !== 1'b0 || addr !== 32'h0) begin
         n_fail++;
         $display("FAIL err_clear: err=%b addr=%h want 0/0", o_err, addr);
      end
   endtask

   task automatic test_small_mem();
      @(posedge clk); #1;
      rst4 = 1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
      end
      n_checks++;
      if (c4 !== 32'd4 || p4 !== 32'hC || v4 !== 1'b1 || e4 !== 1'b0) begin
         n_fail++;
         $display("FAIL small_mem_run: cnt=%0d pc=%h v=%b err=%b want 4/c/1/0",
                  c4, p4, v4, e4);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (v4 !== 1'b0 || e4 !== 1'b1 || c4 !== 32'd4 || a4 !== 32'h10) begin
            n_fail++;
            $display("FAIL small_mem_oob%0d: v=%b err=%b cnt=%0d addr=%h",
                     i, v4, e4, c4, a4);
         end
      end
   endtask

   task automatic test_edges();
      do_reset();
      step();
      redir = 1; rpc = 32'hFFFF_FFFC;
      step();
      redir = 0; flush = 1;
      step();
      flush = 0;
      n_checks++;
      if (addr !== 32'h0 || o_valid !== 1'b0 || o_err !== 1'b0) begin
         n_fail++;
         $display("FAIL pc_wrap: addr=%h v=%b err=%b want 0/0/0",
                  addr, o_valid, o_err);
      end
      redir = 1; rpc = 32'h3FC;
      step();
      redir = 0;
      step();
      n_checks++;
      if (o_pc !== 32'h3FC || o_valid !== 1'b1 || o_err !== 1'b0) begin
         n_fail++;
         $display("FAIL last_word: pc=%h v=%b err=%b want 3fc/1/0",
                  o_pc, o_valid, o_err);
      end
      step();
      n_checks++;
      if (o_valid !== 1'b0 || o_err !== 1'b1 || addr !== 32'h400) begin
         n_fail++;
         $display("FAIL oob: v=%b err=%b addr=%h want 0/1/400",
                  o_valid, o_err, addr);
      end
   endtask

   task automatic test_flush_async_reset();
      do_reset();
      for (int i = 0; i < 6; i++) step();
      n_checks++;
      if (addr !== 32'd20) begin
         n_fail++;
         $display("FAIL flush_setup: addr=%h want 14", addr);
      end
      flush = 1;
      step();
      flush = 0;
      n_checks++;
      if ({o_pc, o_pc4, o_instr, o_valid, addr, o_cnt} !==
          {32'h0, 32'h0, 32'h0, 1'b0, 32'd24, 32'd5}) begin
         n_fail++;
         $display("FAIL flush: pc=%h v=%b addr=%h cnt=%0d want 0/0/18/5",
                  o_pc, o_valid, addr, o_cnt);
      end
      step();
      #2;
      rst_n = 0;
      #1;
      n_checks++;
      if ({addr, o_pc, o_instr, o_valid, o_err, o_cnt} !==
          {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL async_reset: addr=%h pc=%h v=%b cnt=%0d",
                  addr, o_pc, o_valid, o_cnt);
      end
      rst_n = 1;
      m_reset();
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 7) == 0);
         redir = ($urandom_range(0, 9) == 0);
         rpc   = $urandom_range(0, 300) * 4;
         if ($urandom_range(0, 29) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
         step();
         n_checks++;
         if ({addr, o_pc, o_pc4, o_instr, o_valid, o_err, o_cnt} !==
             {m_pc, m_ipc, m_ipc4, m_iins, m_val, m_err, m_cnt}) begin
            n_fail++;
            bad++;
            if (bad < 5)
               $display("FAIL random@%0d: addr=%h/%h pc=%h/%h ins=%h/%h v=%b/%b err=%b/%b cnt=%0d/%0d",
                        c, addr, m_pc, o_pc, m_ipc, o_instr, m_iins,
                        o_valid, m_val, o_err, m_err, o_cnt, m_cnt);
         end
         if (m_err && $urandom_range(0, 4) == 0) do_reset();
      end
      stall = 0; flush = 0; redir = 0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'(i + 1);
      #2;
      rst_n = 1;
      test_reset();
      test_boot_and_fetch();
      test_stall();
      test_redirect();
      test_misaligned();
      test_small_mem();
      test_edges();
      test_flush_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
